// File: rtl/uart_pkg.sv
// Shared UART packet layout and lock-FSM encoding.
// Used by the receive-side deframer and the transmit-side packet builder.
// Pure definitions: no logic, no latency, no flow control.
package uart_pkg;

  // Bit positions inside the 11-bit UART packet.
  localparam int START_B  = 0;
  localparam int DATA_LSB = 1;
  localparam int DATA_MSB = 8;
  localparam int PAR_B    = 9;
  localparam int STOP_B   = 10;
  localparam int PKT_W    = 11;
  localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

  // Link lock state.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Nonzero when the parity bit disagrees with the data under the selected sense.
  function automatic logic parity_bad(input logic [DATA_W-1:0] dat,
                                      input logic par,
                                      input logic odd);
    return (^dat) ^ par ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Packet-in / byte-out bundle between the UART receiver, deframer and byte consumer.
// Packet side is a bare one-cycle strobe; byte side is valid/ready.
// slave = deframer view, master = upstream/consumer (test) view.
interface uart_rx_deframer_if;
  import uart_pkg::*;

  logic [PKT_W-1:0]  pkt_in;
  logic              pkt_valid;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output pkt_in, pkt_valid, byte_ready,
    input  byte_out, byte_valid
  );

  modport slave (
    input  pkt_in, pkt_valid, byte_ready,
    output byte_out, byte_valid
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Show-ahead synchronous FIFO: head data is visible whenever not empty.
// Latency: a push is visible at the output one cycle later.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               pop_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == FULL_LVL);
  assign level_o   = level_q;
  // Pop on empty is ignored; a full FIFO still accepts a push when it pops.
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  // Drive zero while empty so the head never shows stale storage.
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/uart_rx_deframer.sv
// Checks UART packet framing/parity, tracks link lock, buffers good bytes in a FIFO.
// Latency: pkt_valid at N gives byte_valid at N+2 into an empty FIFO; never stalls.
// Backpressure: byte_ready pops the FIFO; pushes into a full FIFO are dropped and counted.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int PARITY_ODD    = 0,
  parameter int GOOD_TO_LOCK  = 2,
  parameter int BAD_TO_UNLOCK = 3,
  parameter int CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_rx_deframer_if.slave             bus,
  output logic                          locked,
  output logic [CNT_W-1:0]              frame_err_cnt,
  output logic [CNT_W-1:0]              parity_err_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int GW = $clog2(GOOD_TO_LOCK + 1);
  localparam int BW = $clog2(BAD_TO_UNLOCK + 1);

  // Stage 1: latched packet and its check flags.
  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_dat_q;
  logic              s1_ferr_q, s1_perr_q;
  logic              ferr_in, perr_in;

  // Stage 2: lock FSM.
  lock_state_e       state_q, state_d;
  logic [GW-1:0]     good_run_q, good_run_d;
  logic [BW-1:0]     bad_run_q, bad_run_d;
  logic              push;

  logic              fifo_full, fifo_empty, fifo_pop;

  assign ferr_in = bus.pkt_in[START_B] || !bus.pkt_in[STOP_B];
  assign perr_in = !ferr_in && parity_bad(bus.pkt_in[DATA_MSB:DATA_LSB],
                                          bus.pkt_in[PAR_B], 1'(PARITY_ODD));

  // Capture each incoming packet with its framing/parity verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      s1_ferr_q <= 1'b0;
      s1_perr_q <= 1'b0;
    end else begin
      s1_vld_q <= bus.pkt_valid;
      if (bus.pkt_valid) begin
        s1_dat_q  <= bus.pkt_in[DATA_MSB:DATA_LSB];
        s1_ferr_q <= ferr_in;
        s1_perr_q <= perr_in;
      end
    end
  end

  // Lock FSM: decide next state, run counters and whether the byte is pushed.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    push       = 1'b0;
    if (s1_vld_q) begin
      case (state_q)
        HUNT: begin
          if (s1_ferr_q || s1_perr_q) begin
            good_run_d = '0;
          end else if (good_run_q + GW'(1) == GW'(GOOD_TO_LOCK)) begin
            // The packet that completes the run is the first one delivered.
            state_d    = LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
            push       = 1'b1;
          end else begin
            good_run_d = good_run_q + GW'(1);
          end
        end
        LOCKED: begin
          if (s1_ferr_q) begin
            if (bad_run_q + BW'(1) == BW'(BAD_TO_UNLOCK)) begin
              state_d    = HUNT;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              bad_run_d = bad_run_q + BW'(1);
            end
          end else begin
            // Parity errors discard the byte but do not threaten lock.
            bad_run_d = '0;
            push      = !s1_perr_q;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Lock FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      good_run_q <= '0;
      bad_run_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign fifo_pop = bus.byte_valid && bus.byte_ready;

  // Saturating error and drop counters for the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
      drop_cnt       <= '0;
    end else begin
      if (s1_vld_q && s1_ferr_q && frame_err_cnt != '1)
        frame_err_cnt <= frame_err_cnt + CNT_W'(1);
      if (s1_vld_q && s1_perr_q && parity_err_cnt != '1)
        parity_err_cnt <= parity_err_cnt + CNT_W'(1);
      if (push && fifo_full && !fifo_pop && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (s1_dat_q),
    .pop_i      (fifo_pop),
    .pop_dat_o  (bus.byte_out),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign bus.byte_valid = !fifo_empty;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: table of per-cycle vectors plus hand sequences.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
// Even parity, FIFO depth 8, lock after 2 good, unlock after 3 framing errors.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic [7:0] frame_err_cnt, parity_err_cnt, drop_cnt;
  logic [3:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_deframer_if bus ();

  uart_rx_deframer #(
    .FIFO_DEPTH(8), .PARITY_ODD(0), .GOOD_TO_LOCK(2), .BAD_TO_UNLOCK(3), .CNT_W(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .locked         (locked),
    .frame_err_cnt  (frame_err_cnt),
    .parity_err_cnt (parity_err_cnt),
    .drop_cnt       (drop_cnt),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [10:0] pkt;
    logic        rdy;
    logic        e_vld;
    logic [7:0]  e_byte;
    logic        e_lock;
    logic [3:0]  e_lvl;
    logic [7:0]  e_ferr;
    logic [7:0]  e_perr;
  } vec_t;

  vec_t tbl [16];

  // Packet builders (even parity): {stop, parity, data, start}.
  function automatic logic [10:0] pk_good(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction
  function automatic logic [10:0] pk_nostop(input logic [7:0] d);
    return {1'b0, ^d, d, 1'b0};
  endfunction
  function automatic logic [10:0] pk_badpar(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] p);
    bus.pkt_valid = 1'b1;
    bus.pkt_in    = p;
    step();
    bus.pkt_valid = 1'b0;
  endtask

  initial begin
    logic [10:0] ref5a;
    reset          = 1'b1;
    bus.pkt_valid  = 1'b0;
    bus.pkt_in     = '0;
    bus.byte_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state.
    check("rst_vld",   bus.byte_valid, 0);
    check("rst_byte",  bus.byte_out, 0);
    check("rst_level", fifo_level, 0);
    check("rst_lock",  locked, 0);
    check("rst_ferr",  frame_err_cnt, 0);
    check("rst_perr",  parity_err_cnt, 0);
    check("rst_drop",  drop_cnt, 0);

    ref5a = 11'b1_0_01011010_0;
    check("pkt5a_build", pk_good(8'h5A), ref5a);

    // Per-cycle table: each row drives inputs for one cycle, then checks the state after it.
    //          pv   pkt                rdy  vld  byte   lock lvl  ferr perr
    tbl[0]  = '{1'b1, pk_good(8'h5A),   1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, pk_good(8'h3C),   1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'd0, 8'd0};
    tbl[2]  = '{1'b1, pk_good(8'h81),   1'b0, 1'b1, 8'h3C, 1'b1, 4'd1, 8'd0, 8'd0};
    tbl[3]  = '{1'b0, 11'h0,            1'b0, 1'b1, 8'h3C, 1'b1, 4'd2, 8'd0, 8'd0};
    tbl[4]  = '{1'b0, 11'h0,            1'b1, 1'b1, 8'h81, 1'b1, 4'd1, 8'd0, 8'd0};
    tbl[5]  = '{1'b0, 11'h0,            1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 8'd0, 8'd0};
    // Locked: one framing error, one parity error; neither byte is buffered.
    tbl[6]  = '{1'b1, pk_nostop(8'h11), 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'd0, 8'd0};
    tbl[7]  = '{1'b1, pk_badpar(8'h22), 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'd1, 8'd0};
    tbl[8]  = '{1'b0, 11'h0,            1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'd1, 8'd1};
    // Three framing errors in a row drop lock; next good is hunted, second relocks.
    tbl[9]  = '{1'b1, pk_nostop(8'h33), 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'd1, 8'd1};
    tbl[10] = '{1'b1, pk_nostop(8'h34), 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'd2, 8'd1};
    tbl[11] = '{1'b1, pk_nostop(8'h35), 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'd3, 8'd1};
    tbl[12] = '{1'b1, pk_good(8'h44),   1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'd4, 8'd1};
    tbl[13] = '{1'b1, pk_good(8'h55),   1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'd4, 8'd1};
    tbl[14] = '{1'b0, 11'h0,            1'b0, 1'b1, 8'h55, 1'b1, 4'd1, 8'd4, 8'd1};
    tbl[15] = '{1'b0, 11'h0,            1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 8'd4, 8'd1};

    for (int i = 0; i < 16; i++) begin
      bus.pkt_valid  = tbl[i].pv;
      bus.pkt_in     = tbl[i].pkt;
      bus.byte_ready = tbl[i].rdy;
      step();
      check($sformatf("row%0d_vld", i),   bus.byte_valid, tbl[i].e_vld);
      if (tbl[i].e_vld)
        check($sformatf("row%0d_byte", i), bus.byte_out, tbl[i].e_byte);
      check($sformatf("row%0d_lock", i),  locked, tbl[i].e_lock);
      check($sformatf("row%0d_level", i), fifo_level, tbl[i].e_lvl);
      check($sformatf("row%0d_ferr", i),  frame_err_cnt, tbl[i].e_ferr);
      check($sformatf("row%0d_perr", i),  parity_err_cnt, tbl[i].e_perr);
      check($sformatf("row%0d_drop", i),  drop_cnt, 0);
    end
    bus.pkt_valid  = 1'b0;
    bus.byte_ready = 1'b0;

    // Overflow: 10 back-to-back good bytes with no consumer.
    for (int i = 0; i < 10; i++) send(pk_good(8'(i)));
    step();
    check("ovf_level", fifo_level, 8);
    check("ovf_drop",  drop_cnt, 2);
    check("ovf_lock",  locked, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_vld", i),  bus.byte_valid, 1);
      check($sformatf("drain%0d_byte", i), bus.byte_out, i);
      bus.byte_ready = 1'b1;
      step();
    end
    check("drain_empty", bus.byte_valid, 0);
    check("drain_level", fifo_level, 0);
    // byte_ready high on an empty FIFO is harmless.
    step();
    check("empty_pop_level", fifo_level, 0);
    bus.byte_ready = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) send(pk_good(8'h10 + 8'(i)));
    step();
    check("full_level", fifo_level, 8);
    check("full_drop",  drop_cnt, 2);
    send(pk_good(8'h20));
    bus.byte_ready = 1'b1;
    step();
    bus.byte_ready = 1'b0;
    check("pp_level", fifo_level, 8);
    check("pp_drop",  drop_cnt, 2);
    check("pp_head",  bus.byte_out, 8'h11);

    // Drain three to leave five, then reset with a packet arriving.
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.byte_ready = 1'b0;
    check("pre_rst_level", fifo_level, 5);
    check("pre_rst_head",  bus.byte_out, 8'h14);
    reset         = 1'b1;
    bus.pkt_valid = 1'b1;
    bus.pkt_in    = pk_good(8'h77);
    step();
    check("mid_rst_vld",   bus.byte_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_lock",  locked, 0);
    check("mid_rst_ferr",  frame_err_cnt, 0);
    check("mid_rst_perr",  parity_err_cnt, 0);
    check("mid_rst_drop",  drop_cnt, 0);
    reset         = 1'b0;
    bus.pkt_valid = 1'b0;
    step();
    step();
    check("post_rst_level", fifo_level, 0);
    check("post_rst_lock",  locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
